// File: rtl/ldl_crc_pkg.sv
// ldl_crc_pkg
// Shared CRC-32/MPEG-2 constants and the single-byte update helper used by
// the LDL CRC checker. Polynomial 0x04C11DB7, MSB-first, no reflection,
// no final XOR. Running the CRC over a packet including its big-endian
// trailer leaves a residue of zero when the trailer is correct.
package ldl_crc_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam int          CRC_BYTES  = 4;

    // Fold one byte into the CRC, most significant bit first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {data, 24'h00_0000};
        for (int k = 0; k < 8; k++) begin
            c = {c[30:0], 1'b0} ^ (c[31] ? CRC32_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/ldl_crc32_update.sv
// ldl_crc32_update
// Combinational masked multi-byte CRC-32 update. Folds the first nb bytes
// of data (first byte at the top of the word) into crc; remaining bytes
// are ignored.
// Ports:
//   crc      in  32          running CRC before this beat
//   data     in  DATA_WIDTH  beat data, first-on-wire byte in the MSBs
//   nb       in  NB_W        number of leading bytes to fold (0..BYTE_NUM)
//   crc_next out 32          CRC after folding nb bytes
module ldl_crc32_update
    import ldl_crc_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int NB_W       = 6
) (
    input  logic [31:0]           crc,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [NB_W-1:0]       nb,
    output logic [31:0]           crc_next
);

    localparam int BYTE_NUM = DATA_WIDTH / 8;

    // Byte-serial chain; bytes at or beyond nb pass the CRC through unchanged.
    always_comb begin
        logic [31:0] acc_s;
        acc_s = crc;
        for (int i = 0; i < BYTE_NUM; i++) begin
            acc_s = (32'(i) < 32'(nb))
                  ? crc32_byte(acc_s, data[DATA_WIDTH-1-8*i -: 8])
                  : acc_s;
        end
        crc_next = acc_s;
    end

endmodule

// File: rtl/ldl_crc_check.sv
// ldl_crc_check
// Per-flow CRC-32 trailer checker placed ahead of the parity-remove stage.
// The beat stream is passed through with one cycle of latency; err pulses
// alongside vld_out on a beat that ends a bad packet (CRC residue nonzero),
// that disagrees with the packet length about where the packet ends, or
// that starts a packet shorter than 5 bytes. Flows interleave freely.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  1 = check, 0 = bypass (err held 0, state untouched)
//   vld_in, eop_in      beat valid, last beat of packet
//   leng_in             total packet bytes incl. CRC (used on first beat)
//   fid_in              flow id of the beat
//   din                 beat data, first-on-wire byte in the MSBs
//   dout, leng_out, fid_out, vld_out, eop_out   registered copies of inputs
//   err                 registered error pulse, only with vld_out
module ldl_crc_check
    import ldl_crc_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int FLOW_NUM    = 8,
    parameter int LENGTH_BITS = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        vld_in,
    input  logic                        eop_in,
    input  logic [LENGTH_BITS-1:0]      leng_in,
    input  logic [$clog2(FLOW_NUM)-1:0] fid_in,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic [LENGTH_BITS-1:0]      leng_out,
    output logic [$clog2(FLOW_NUM)-1:0] fid_out,
    output logic                        vld_out,
    output logic                        eop_out,
    output logic                        err
);

    localparam int BYTE_NUM = DATA_WIDTH / 8;
    localparam int NB_W     = $clog2(BYTE_NUM + 1);

    logic [FLOW_NUM-1:0]    sof_r;
    logic [LENGTH_BITS-1:0] rem_r [FLOW_NUM];
    logic [31:0]            crc_r [FLOW_NUM];

    logic                   sof_s;
    logic [LENGTH_BITS-1:0] rem_eff_s;
    logic [31:0]            rem_ext_s;
    logic [31:0]            crc_eff_s;
    logic [31:0]            crc_upd_s;
    logic [NB_W-1:0]        nb_s;
    logic                   last_exp_s;
    logic                   check_s;
    logic                   err_s;
    logic                   store_s;
    logic [LENGTH_BITS-1:0] rem_next_s;

    // Select effective remaining count / CRC: fresh on a first beat, stored otherwise.
    always_comb begin
        sof_s      = sof_r[fid_in];
        rem_eff_s  = sof_s ? leng_in    : rem_r[fid_in];
        crc_eff_s  = sof_s ? CRC32_INIT : crc_r[fid_in];
        rem_ext_s  = 32'(rem_eff_s);
        last_exp_s = (rem_ext_s <= 32'(BYTE_NUM));
        nb_s       = last_exp_s ? rem_ext_s[NB_W-1:0] : NB_W'(BYTE_NUM);
        rem_next_s = LENGTH_BITS'(rem_ext_s - 32'(BYTE_NUM));
        check_s    = en & vld_in;
    end

    ldl_crc32_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .NB_W       (NB_W)
    ) u_crc32_update (
        .crc      (crc_eff_s),
        .data     (din),
        .nb       (nb_s),
        .crc_next (crc_upd_s)
    );

    // Classify the beat: error cause, or continue the packet in flow state.
    always_comb begin
        err_s   = 1'b0;
        store_s = 1'b0;
        if (sof_s && (rem_ext_s < 32'd5)) begin
            err_s = 1'b1;
        end else if (eop_in != last_exp_s) begin
            err_s = 1'b1;
        end else if (eop_in) begin
            err_s = (crc_upd_s != 32'h0000_0000);
        end else begin
            store_s = 1'b1;
        end
    end

    // Per-flow packet state; any packet-ending or error beat re-arms sof.
    always_ff @(posedge clk) begin
        if (rst) begin
            sof_r <= {FLOW_NUM{1'b1}};
            for (int f = 0; f < FLOW_NUM; f++) begin
                rem_r[f] <= '0;
                crc_r[f] <= CRC32_INIT;
            end
        end else if (check_s) begin
            if (store_s) begin
                rem_r[fid_in] <= rem_next_s;
                crc_r[fid_in] <= crc_upd_s;
                sof_r[fid_in] <= 1'b0;
            end else begin
                sof_r[fid_in] <= 1'b1;
            end
        end
    end

    // Registered pass-through and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            leng_out <= '0;
            fid_out  <= '0;
            vld_out  <= 1'b0;
            eop_out  <= 1'b0;
            err      <= 1'b0;
        end else begin
            dout     <= din;
            leng_out <= leng_in;
            fid_out  <= fid_in;
            vld_out  <= vld_in;
            eop_out  <= eop_in;
            err      <= check_s & err_s;
        end
    end

endmodule
